// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered AVR-style ALU with iterative MUL/MULS/MULSU multiplier
// Optional FMUL/FMULS/FMULSU on op codes 12-14 when ALU_SEQ_FMUL_EN is defined.
module alu_seq #(
    parameter int WIDTH    = 8,
    parameter int MUL_STEP = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] p_hi_o,
    output logic             c_o,
    output logic             h_o,
    output logic             z_o,
    output logic             v_o,
    output logic             n_o
);
    localparam int N  = WIDTH / MUL_STEP;
    localparam int CW = $clog2(N);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_PASS  = 4'd5;
    localparam logic [3:0] OP_ROR   = 4'd6;
    localparam logic [3:0] OP_SWAP  = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_MULS  = 4'd9;
    localparam logic [3:0] OP_MULSU = 4'd10;
    localparam logic [3:0] OP_ASR   = 4'd11;
`ifdef ALU_SEQ_FMUL_EN
    localparam logic [3:0] OP_FMUL   = 4'd12;
    localparam logic [3:0] OP_FMULS  = 4'd13;
    localparam logic [3:0] OP_FMULSU = 4'd14;
`endif

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_b_signed;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   r_p_hi;
    logic               r_c, r_h, r_z, r_v, r_n;
`ifdef ALU_SEQ_FMUL_EN
    logic               r_fmul;
    logic               w_fmul;
`endif

    logic               w_is_mul, w_a_signed, w_b_signed;
    logic [WIDTH:0]     w_add, w_sub;
    logic [WIDTH-1:0]   w_alu_s;
    logic               w_alu_c, w_alu_h, w_alu_v, w_alu_z, w_alu_n, w_zn_en;
    logic [2*WIDTH-1:0] w_acc_nxt, w_mcand_nxt, w_store;
    logic [WIDTH-1:0]   w_mplier_nxt;

    always_comb begin
        w_is_mul   = 1'b0;
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (op_i)
            OP_MUL:   w_is_mul = 1'b1;
            OP_MULS:  begin w_is_mul = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; end
            OP_MULSU: begin w_is_mul = 1'b1; w_a_signed = 1'b1; end
`ifdef ALU_SEQ_FMUL_EN
            OP_FMUL:   w_is_mul = 1'b1;
            OP_FMULS:  begin w_is_mul = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; end
            OP_FMULSU: begin w_is_mul = 1'b1; w_a_signed = 1'b1; end
`endif
            default: ;
        endcase
    end

`ifdef ALU_SEQ_FMUL_EN
    assign w_fmul = w_is_mul && (op_i[3:2] == 2'b11);
`endif

    assign w_add = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};
    assign w_sub = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, c_i};

    // Carry/borrow into bit 4 recovered as a[4]^b[4]^s[4].
    always_comb begin
        w_alu_s = a_i;
        w_alu_c = 1'b0;
        w_alu_h = 1'b0;
        w_alu_v = 1'b0;
        w_zn_en = 1'b1;
        case (op_i)
            OP_ADD: begin
                w_alu_s = w_add[WIDTH-1:0];
                w_alu_c = w_add[WIDTH];
                w_alu_h = a_i[4] ^ b_i[4] ^ w_add[4];
                w_alu_v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_add[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_s = w_sub[WIDTH-1:0];
                w_alu_c = w_sub[WIDTH];
                w_alu_h = a_i[4] ^ b_i[4] ^ w_sub[4];
                w_alu_v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_sub[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  w_alu_s = a_i & b_i;
            OP_OR:   w_alu_s = a_i | b_i;
            OP_XOR:  w_alu_s = a_i ^ b_i;
            OP_PASS: w_alu_s = a_i;
            OP_ROR: begin
                w_alu_s = {c_i, a_i[WIDTH-1:1]};
                w_alu_c = a_i[0];
                w_alu_v = c_i ^ a_i[0];
            end
            OP_SWAP: w_alu_s = {a_i[WIDTH/2-1:0], a_i[WIDTH-1:WIDTH/2]};
            OP_ASR: begin
                w_alu_s = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
                w_alu_c = a_i[0];
                w_alu_v = a_i[WIDTH-1] ^ a_i[0];
            end
            default: w_zn_en = 1'b0;
        endcase
        w_alu_n = w_zn_en & w_alu_s[WIDTH-1];
        w_alu_z = w_zn_en & (w_alu_s == '0);
    end

    // Shift-add over B; the final bit of a signed B carries negative weight.
    always_comb begin
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (w_mplier_nxt[0]) begin
                if (r_b_signed && (r_cnt == '0) && (j == MUL_STEP - 1))
                    w_acc_nxt = w_acc_nxt - w_mcand_nxt;
                else
                    w_acc_nxt = w_acc_nxt + w_mcand_nxt;
            end
            w_mcand_nxt  = w_mcand_nxt << 1;
            w_mplier_nxt = w_mplier_nxt >> 1;
        end
    end

`ifdef ALU_SEQ_FMUL_EN
    assign w_store = r_fmul ? {w_acc_nxt[2*WIDTH-2:0], 1'b0} : w_acc_nxt;
`else
    assign w_store = w_acc_nxt;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_b_signed <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_s        <= '0;
            r_p_hi     <= '0;
            r_c        <= 1'b0;
            r_h        <= 1'b0;
            r_z        <= 1'b0;
            r_v        <= 1'b0;
            r_n        <= 1'b0;
`ifdef ALU_SEQ_FMUL_EN
            r_fmul     <= 1'b0;
`endif
        end else if (ena_i) begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        if (w_is_mul) begin
                            r_state    <= S_MUL;
                            r_busy     <= 1'b1;
                            r_cnt      <= CW'(N - 1);
                            r_acc      <= '0;
                            r_mcand    <= {{WIDTH{w_a_signed & a_i[WIDTH-1]}}, a_i};
                            r_mplier   <= b_i;
                            r_b_signed <= w_b_signed;
`ifdef ALU_SEQ_FMUL_EN
                            r_fmul     <= w_fmul;
`endif
                        end else begin
                            r_done <= 1'b1;
                            r_s    <= w_alu_s;
                            r_p_hi <= '0;
                            r_c    <= w_alu_c;
                            r_h    <= w_alu_h;
                            r_z    <= w_alu_z;
                            r_v    <= w_alu_v;
                            r_n    <= w_alu_n;
                        end
                    end
                end
                S_MUL: begin
                    r_done   <= 1'b0;
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= w_mcand_nxt;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state         <= S_IDLE;
                        r_busy          <= 1'b0;
                        r_done          <= 1'b1;
                        {r_p_hi, r_s}   <= w_store;
                        r_c             <= w_acc_nxt[2*WIDTH-1];
                        r_z             <= (w_store == '0);
                        r_h             <= 1'b0;
                        r_v             <= 1'b0;
                        r_n             <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign s_o    = r_s;
    assign p_hi_o = r_p_hi;
    assign c_o    = r_c;
    assign h_o    = r_h;
    assign z_o    = r_z;
    assign v_o    = r_v;
    assign n_o    = r_n;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed table-driven bench for alu_seq (8-bit/step 1 and 16-bit/step 4)
module tb_alu_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       ena8, start8, c8;
    logic [3:0] op8;
    logic [7:0] a8, b8;
    logic       busy8, done8, co8, ho8, zo8, vo8, no8;
    logic [7:0] s8, phi8;
    logic [4:0] f8;

    logic        ena16, start16, c16;
    logic [3:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16, co16, ho16, zo16, vo16, no16;
    logic [15:0] s16, phi16;
    logic [4:0]  f16;

    assign f8  = {co8, ho8, zo8, vo8, no8};
    assign f16 = {co16, ho16, zo16, vo16, no16};

    int n_err = 0;
    int n_chk = 0;

    alu_seq #(.WIDTH(8), .MUL_STEP(1)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .ena_i(ena8), .start_i(start8), .op_i(op8),
        .a_i(a8), .b_i(b8), .c_i(c8), .busy_o(busy8), .done_o(done8),
        .s_o(s8), .p_hi_o(phi8), .c_o(co8), .h_o(ho8), .z_o(zo8), .v_o(vo8), .n_o(no8)
    );

    alu_seq #(.WIDTH(16), .MUL_STEP(4)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .ena_i(ena16), .start_i(start16), .op_i(op16),
        .a_i(a16), .b_i(b16), .c_i(c16), .busy_o(busy16), .done_o(done16),
        .s_o(s16), .p_hi_o(phi16), .c_o(co16), .h_o(ho16), .z_o(zo16), .v_o(vo16), .n_o(no16)
    );

    typedef struct {
        string      nm;
        logic [3:0] op;
        logic [7:0] a, b;
        logic       c;
        logic [7:0] s, phi;
        logic [4:0] f;      // {C,H,Z,V,N}
        int         lat;    // edges after the accepting edge
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic [3:0] op, input logic [7:0] a, b,
                           input logic c, input logic [7:0] s, phi, input logic [4:0] f, input int lat);
        vec_t v;
        v.nm = nm; v.op = op; v.a = a; v.b = b; v.c = c;
        v.s = s; v.phi = phi; v.f = f; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s got %h want %h", nm, what, act, exp);
        end
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] a, b, input logic c, output int lat);
        op8 = op; a8 = a; b8 = b; c8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    int lat, busy_cnt;
    logic seen_done;

    initial begin
        rst = 1'b1;
        ena8 = 1'b1; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; c8 = 1'b0;
        ena16 = 1'b1; start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; c16 = 1'b0;
        repeat (2) tick();
        chk("reset8", "busy_done", {busy8, done8}, 2'b00);
        chk("reset8", "s_phi", {phi8, s8}, 16'h0000);
        chk("reset8", "flags", f8, 5'b00000);
        chk("reset16", "all", {busy16, done16, phi16, s16, f16}, '0);
        rst = 1'b0;
        tick();

        //       name        op     a      b      c     s      phi    CHZVN     lat
        add_vec("add_ovf",   4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 5'b01011, 0);
        add_vec("sub_brw",   4'd1,  8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 5'b11001, 0);
        add_vec("ror",       4'd6,  8'h01, 8'h00, 1'b1, 8'h80, 8'h00, 5'b10001, 0);
        add_vec("swap",      4'd7,  8'hA5, 8'h00, 1'b0, 8'h5A, 8'h00, 5'b00000, 0);
        add_vec("asr",       4'd11, 8'h81, 8'h00, 1'b0, 8'hC0, 8'h00, 5'b10001, 0);
        add_vec("rsv15",     4'd15, 8'h3C, 8'h00, 1'b1, 8'h3C, 8'h00, 5'b00000, 0);
        add_vec("and_z",     4'd2,  8'hF0, 8'h0F, 1'b0, 8'h00, 8'h00, 5'b00100, 0);
        add_vec("or_n",      4'd3,  8'h80, 8'h01, 1'b0, 8'h81, 8'h00, 5'b00001, 0);
        add_vec("xor_z",     4'd4,  8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 5'b00100, 0);
        add_vec("pass_z",    4'd5,  8'h00, 8'h77, 1'b0, 8'h00, 8'h00, 5'b00100, 0);
        add_vec("add_cz",    4'd0,  8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 5'b11100, 0);
        add_vec("sub_ovf",   4'd1,  8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 5'b01010, 0);
        add_vec("mul_ff",    4'd8,  8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 5'b10000, 8);
        add_vec("muls_min",  4'd9,  8'h80, 8'h80, 1'b0, 8'h00, 8'h40, 5'b00000, 8);
        add_vec("mulsu_neg", 4'd10, 8'hFF, 8'h02, 1'b0, 8'hFE, 8'hFF, 5'b10000, 8);
        add_vec("mul_zero",  4'd8,  8'h00, 8'h5A, 1'b0, 8'h00, 8'h00, 5'b00100, 8);
        add_vec("muls_m1",   4'd9,  8'hFF, 8'hFF, 1'b0, 8'h01, 8'h00, 5'b00000, 8);
        add_vec("muls_mix",  4'd9,  8'h7F, 8'h80, 1'b0, 8'h80, 8'hC0, 5'b10000, 8);
`ifdef ALU_SEQ_FMUL_EN
        add_vec("fmul",      4'd12, 8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 5'b00000, 8);
        add_vec("fmuls",     4'd13, 8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 5'b00000, 8);
`else
        add_vec("rsv12",     4'd12, 8'h80, 8'h80, 1'b0, 8'h80, 8'h00, 5'b00000, 0);
        add_vec("rsv13",     4'd13, 8'h80, 8'h80, 1'b0, 8'h80, 8'h00, 5'b00000, 0);
`endif

        foreach (vecs[i]) begin
            run8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, lat);
            chk(vecs[i].nm, "lat", lat, vecs[i].lat);
            chk(vecs[i].nm, "s", s8, vecs[i].s);
            chk(vecs[i].nm, "phi", phi8, vecs[i].phi);
            chk(vecs[i].nm, "flags", f8, vecs[i].f);
            tick();
            chk(vecs[i].nm, "done_pulse", done8, 1'b0);
        end

        // MUL with a stray start mid-operation, then back-to-back accept on the done cycle
        op8 = 4'd8; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        busy_cnt = busy8 ? 1 : 0;
        lat = 0;
        while (!done8 && lat < 40) begin
            if (lat == 2) begin
                start8 = 1'b1; op8 = 4'd0; a8 = 8'h01; b8 = 8'h01;
            end else begin
                start8 = 1'b0;
            end
            tick();
            lat++;
            if (busy8) busy_cnt++;
        end
        chk("mul_stray", "lat", lat, 8);
        chk("mul_stray", "busy_cycles", busy_cnt, 8);
        chk("mul_stray", "prod", {phi8, s8}, 16'hFE01);
        chk("mul_stray", "c", co8, 1'b1);
        start8 = 1'b1; op8 = 4'd0; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
        tick();
        start8 = 1'b0;
        chk("b2b", "done", done8, 1'b1);
        chk("b2b", "s_phi", {phi8, s8}, 16'h0002);
        tick();
        chk("b2b", "done_low", done8, 1'b0);
        chk("b2b", "s_hold", s8, 8'h02);

        // Reset at the third MUL cycle abandons the multiply
        op8 = 4'd8; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid", "busy_done", {busy8, done8}, 2'b00);
        chk("rst_mid", "s_phi", {phi8, s8}, 16'h0000);
        chk("rst_mid", "flags", f8, 5'b00000);
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen_done |= done8;
        end
        chk("rst_mid", "no_done", seen_done, 1'b0);

        // 16-bit, 4 bits per cycle
        op16 = 4'd0; a16 = 16'h000F; b16 = 16'h0001; c16 = 1'b0; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        chk("add16", "done_s", {done16, s16}, {1'b1, 16'h0010});
        chk("add16", "flags", f16, 5'b01000);

        op16 = 4'd8; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 40) begin
            tick();
            lat++;
        end
        chk("mul16", "lat", lat, 4);
        chk("mul16", "prod", {phi16, s16}, 32'hFFFE0001);
        chk("mul16", "c", co16, 1'b1);

        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick();
        lat = 1;
        ena16 = 1'b0;
        tick();
        tick();
        lat += 2;
        chk("mul16_stall", "busy_done", {busy16, done16}, 2'b10);
        ena16 = 1'b1;
        while (!done16 && lat < 40) begin
            tick();
            lat++;
        end
        chk("mul16_stall", "lat", lat, 6);
        chk("mul16_stall", "prod", {phi16, s16}, 32'hFFFE0001);
        tick();
        chk("mul16_stall", "done_low", done16, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the AVR ALU: WIDTH-bit datapath with the same add/sub/logic/shift/swap operations.
- Adds an iterative multiplier for the MUL, MULS and MULSU operations, plus an ASR operation.
- Sits between the register-file read port and the write-back stage, with a start/busy/done handshake.
- The core controller stalls the pipeline on busy_o.

Parameters:
- WIDTH, 8, operand/result width; even, >= 8.
- MUL_STEP, 1, multiplier bits retired per cycle; must be 1, 2 or 4 and divide WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- ena_i  in  1  clock enable; low freezes all state and outputs.
- start_i  in  1  launch operation; sampled only when not busy.
- op_i  in  4  operation code, see Behaviour.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- c_i  in  1  carry in.
- busy_o  out  1  multiply in progress.
- done_o  out  1  one-cycle pulse when results update.
- s_o  out  WIDTH  result, or product low half.
- p_hi_o  out  WIDTH  product high half; 0 for non-multiply operations.
- c_o, h_o, z_o, v_o, n_o  out  1 each  flags.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset clears everything: state IDLE, busy_o=0, done_o=0, s_o=0, p_hi_o=0, all flags 0. Reset overrides ena_i.
- Operand capture: a_i, b_i, c_i and op_i are captured on the accepting edge and need not be held afterwards.
- Op codes:
  - 0 ADD: A+B+c_i.
  - 1 SUB: A-B-c_i.
  - 2 AND, 3 OR, 4 XOR.
  - 5 PASS: A.
  - 6 ROR: {c_i, A[W-1:1]}.
  - 7 SWAP: {A[W/2-1:0], A[W-1:W/2]}.
  - 8 MUL: unsigned x unsigned.
  - 9 MULS: signed x signed.
  - 10 MULSU: A signed x B unsigned.
  - 11 ASR: {A[W-1], A[W-1:1]}.
  - 12-15 reserved: behave as PASS with all flags 0.
- FSM states: IDLE, MUL.
- IDLE, start_i=1 at edge t0 with ena_i=1:
  - Single-cycle op: results, flags and done_o=1 are registered at edge t0 (latency 1).
  - Multiply op: state goes to MUL, the iteration counter loads N-1 where N=WIDTH/MUL_STEP, and busy_o=1.
- MUL: each enabled edge retires MUL_STEP bits.
  - On the edge where the counter is 0: state goes to IDLE, busy_o=0, done_o=1, and {p_hi_o, s_o} is loaded with the full 2*WIDTH product.
  - Total latency is N enabled edges.
- Signed products: must equal the exact two's-complement 2*WIDTH-bit product, e.g. MULS of -2^(W-1) by -2^(W-1) gives +2^(2W-2).
- start_i while busy_o=1 is ignored. start_i in the cycle where done_o=1 and state is IDLE is accepted (back-to-back).
- done_o is high for exactly one enabled cycle. Outputs hold their values until the next done.
- Flags:
  - ADD/SUB: C = carry/borrow out of the MSB. H = carry/borrow out of bit 3. V = signed overflow. N = MSB of s. Z = (s==0).
  - Logic/PASS/SWAP: C=H=V=0; N and Z from s.
  - ROR/ASR: C = A[0], N = s MSB, V = N xor C, H=0, Z from s.
  - Multiply: C = product bit 2W-1, Z = (product==0), N=V=H=0.
- Reset mid-multiply: MUL is abandoned, no done_o pulse, outputs cleared.
- ena_i=0 during MUL: the counter and partial product freeze, and done_o is delayed by one cycle per stalled cycle.

Optional Feature:
- Macro: ALU_SEQ_FMUL_EN.
- Defined: op codes 12 FMUL, 13 FMULS and 14 FMULSU perform the same multiplies as 8, 9 and 10, but the stored product is shifted left 1.
  - C = bit 2W-1 of the unshifted product.
  - Z is computed on the shifted product.
  - Latency is identical to the plain multiplies.
- Undefined: codes 12-14 are reserved (PASS, flags 0). No extra logic is synthesised.

Test Plan:
1. WIDTH=8, ADD a=0x7F b=0x01 c=0 -> s_o=0x80, C=0 H=1 V=1 N=1 Z=0, done_o one cycle after start. SUB a=0x00 b=0x01 c=0 -> s_o=0xFF, C=1 H=1 V=0 N=1.
2. ROR a=0x01 c_i=1 -> s_o=0x80, C=1 N=1 V=0. SWAP a=0xA5 -> 0x5A. ASR a=0x81 -> 0xC0, C=1 V=0. Op 15 a=0x3C -> 0x3C with all flags 0.
3. MUL a=0xFF b=0xFF, MUL_STEP=1 -> {p_hi_o,s_o}=0xFE01, C=1. busy_o high 8 cycles, done_o at the 8th edge. A start_i pulse mid-operation is ignored.
4. MULS a=0x80 b=0x80 -> 0x4000, C=0. MULSU a=0xFF b=0x02 -> 0xFFFE, C=1. MUL a=0x00 b=0x5A -> 0x0000, Z=1.
5. WIDTH=16, MUL_STEP=4, MUL 0xFFFF x 0xFFFF -> 0xFFFE0001, done after 4 edges. Hold ena_i low 2 cycles mid-operation -> done after 6 edges, same result.
6. rst_i for 1 cycle at the 3rd MUL cycle -> busy_o=0, no done_o, outputs 0. With ALU_SEQ_FMUL_EN, FMUL a=0x80 b=0x80 -> 0x8000, C=0.
